// File: rtl/ps2_kbd_rx_fifo.sv
// ps2_kbd_rx_fifo: PS/2 keyboard receiver with frame checking, E0/F0 prefix
// folding and a first-word fall-through event FIFO on a valid/ready port.
// Optional build macro PS2_TYPEMATIC_FILTER_EN drops typematic repeats of the
// key currently held down.
// Ports:
//   clk, resetn                 system clock, async active-high reset
//   ps2_clk, ps2_data           raw PS/2 pins (asynchronous)
//   code_valid/ready            FIFO head handshake
//   code_data/break/ext         head event {byte, F0-prefixed, E0-prefixed}
//   fifo_level                  occupancy
//   key_count                   count of accepted make events (wrapping)
//   overflow, clr_ovf           sticky drop flag and its clear
//   frame_err                   one-cycle pulse on start/parity/stop/timeout error
module ps2_kbd_rx_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [7:0]                    code_data,
  output logic                          code_break,
  output logic                          code_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              key_count,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic                          frame_err
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Input synchronisers; idle PS/2 lines are high
  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  logic w_strobe, w_data;
  assign w_strobe = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
  assign w_data   = r_dat_sync[SYNC_STAGES-1];

  state_t          r_state;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [TW-1:0]   r_to_cnt;
  logic            r_ext_flag, r_brk_flag, r_frame_err;

  logic       w_timeout, w_good, w_evt_req, w_push;
  logic [9:0] w_evt;

  assign w_timeout = (r_state != S_IDLE) && !w_strobe && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_good    = w_strobe && (r_state == S_STOP) && w_data && (^{r_shift, r_parity});
  assign w_evt_req = w_good && (r_shift != 8'hE0) && (r_shift != 8'hF0);
  assign w_evt     = {r_ext_flag, r_brk_flag, r_shift};

  // Receive FSM, prefix flags and error pulse
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_to_cnt    <= '0;
      r_ext_flag  <= 1'b0;
      r_brk_flag  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_state == S_IDLE || w_strobe) r_to_cnt <= '0;
      else                               r_to_cnt <= r_to_cnt + TW'(1);

      if (w_timeout) begin
        r_state     <= S_IDLE;
        r_frame_err <= 1'b1;
        r_ext_flag  <= 1'b0;
        r_brk_flag  <= 1'b0;
      end else if (w_strobe) begin
        case (r_state)
          S_IDLE: begin
            if (!w_data) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift  <= {w_data, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_parity <= w_data;
            r_state  <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (w_good) begin
              if (r_shift == 8'hE0)      r_ext_flag <= 1'b1;
              else if (r_shift == 8'hF0) r_brk_flag <= 1'b1;
              else begin
                r_ext_flag <= 1'b0;
                r_brk_flag <= 1'b0;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  // Held-key tracker: a repeated make of the held key is swallowed
  logic [8:0] r_held;
  logic       r_held_v;
  logic       w_repeat;
  assign w_repeat = !r_brk_flag && r_held_v && (r_held == {r_ext_flag, r_shift});
  assign w_push   = w_evt_req && !w_repeat;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_held   <= '0;
      r_held_v <= 1'b0;
    end else if (w_evt_req) begin
      if (!r_brk_flag) begin
        r_held   <= {r_ext_flag, r_shift};
        r_held_v <= 1'b1;
      end else if (r_held == {r_ext_flag, r_shift}) begin
        r_held_v <= 1'b0;
      end
    end
  end
`else
  assign w_push = w_evt_req;
`endif

  // Event FIFO, entry = {ext, break, byte}
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_count;
  logic [CNT_W-1:0] r_key_count;
  logic          r_overflow;
  logic          w_full, w_pop, w_accept;

  assign w_full   = (r_count == LW'(FIFO_DEPTH));
  assign w_pop    = code_valid & code_ready;
  assign w_accept = w_push & (!w_full | w_pop);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_key_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr] <= w_evt;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept && !w_evt[8]) r_key_count <= r_key_count + CNT_W'(1);
      // A drop in the same cycle as clr_ovf keeps the flag set
      if (w_push && !w_accept) r_overflow <= 1'b1;
      else if (clr_ovf)        r_overflow <= 1'b0;
    end
  end

  assign code_valid = (r_count != '0);
  assign code_data  = r_mem[r_rd][7:0];
  assign code_break = r_mem[r_rd][8];
  assign code_ext   = r_mem[r_rd][9];
  assign fifo_level = r_count;
  assign key_count  = r_key_count;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Directed bench for ps2_kbd_rx_fifo: drives PS/2 frames on the pins, records
// popped events and frame_err pulses, and compares against hand-computed values.
module tb_ps2_kbd_rx_fifo;
  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       code_valid, code_ready = 1'b0;
  logic [7:0] code_data;
  logic       code_break, code_ext;
  logic [3:0] fifo_level;
  logic [7:0] key_count;
  logic       overflow, clr_ovf = 1'b0, frame_err;

  ps2_kbd_rx_fifo dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_valid(code_valid), .code_ready(code_ready), .code_data(code_data),
    .code_break(code_break), .code_ext(code_ext), .fifo_level(fifo_level),
    .key_count(key_count), .overflow(overflow), .clr_ovf(clr_ovf),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: popped events {ext,brk,byte}, frame_err pulses, valid cycles
  logic [9:0] ev_q[$];
  int err_cnt = 0;
  int vld_cnt = 0;
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (code_valid) vld_cnt++;
    if (code_valid && code_ready) ev_q.push_back({code_ext, code_break, code_data});
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wait_clk(1);
    resetn = 1'b1;
    wait_clk(3);
    resetn = 1'b0;
    wait_clk(2);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clk(10);
    ps2_clk = 1'b0;
    wait_clk(20);
    ps2_clk = 1'b1;
    wait_clk(10);
  endtask

  // Sends the first nbits of {stop, parity, byte, start=0}, LSB first
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b1, 11);
  endtask

  // Compare the events recorded since index base against an expected list
  task automatic check_events(input string tag, input int base, input logic [9:0] exp[$]);
    logic [9:0] got;
    check({tag, "_n"}, 32'(ev_q.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < ev_q.size()) ? ev_q[base + i] : 10'h3FF;
      check($sformatf("%s_ev%0d", tag, i), 32'(got), 32'(exp[i]));
    end
  endtask

  int eb, ebase, vbase;
  logic [9:0] exp_q[$];

  initial begin
    // Reset state
    wait_clk(4);
    check("rst_valid", 32'(code_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_data", 32'({code_ext, code_break, code_data}), 0);
    check("rst_kcnt", 32'(key_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_ferr", 32'(frame_err), 0);
    resetn = 1'b0;
    wait_clk(4);

    // Plain make 0x1C
    code_ready = 1'b1;
    eb = err_cnt; ebase = ev_q.size(); vbase = vld_cnt;
    send(8'h1C);
    wait_clk(30);
    exp_q = '{10'h01C};
    check_events("make1c", ebase, exp_q);
    check("make1c_vcyc", 32'(vld_cnt - vbase), 1);
    check("make1c_kcnt", 32'(key_count), 1);
    check("make1c_err", 32'(err_cnt - eb), 0);

    // Break F0 1C
    ebase = ev_q.size();
    send(8'hF0); send(8'h1C);
    wait_clk(30);
    exp_q = '{10'h11C};
    check_events("brk1c", ebase, exp_q);
    check("brk1c_kcnt", 32'(key_count), 1);

    // Extended break E0 F0 75
    ebase = ev_q.size();
    send(8'hE0); send(8'hF0); send(8'h75);
    wait_clk(30);
    exp_q = '{10'h375};
    check_events("ebrk75", ebase, exp_q);
    check("ebrk75_kcnt", 32'(key_count), 1);

    // Bad parity, then bad stop
    eb = err_cnt; ebase = ev_q.size();
    send_bits(8'h1C, 1'b1, 1'b1, 11);
    wait_clk(30);
    check("par_err", 32'(err_cnt - eb), 1);
    check("par_level", 32'(fifo_level), 0);
    send_bits(8'h1C, 1'b0, 1'b0, 11);
    wait_clk(30);
    check("stop_err", 32'(err_cnt - eb), 2);
    check("stop_level", 32'(fifo_level), 0);
    check("bad_nopush", 32'(ev_q.size() - ebase), 0);

    // Overflow: 9 makes into an 8-deep FIFO with no consumer
    do_reset();
    code_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'(8'h16 + i));
    wait_clk(30);
    check("ovf_level", 32'(fifo_level), 8);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_kcnt", 32'(key_count), 8);
    check("ovf_head", 32'(code_data), 32'h16);
    ebase = ev_q.size();
    code_ready = 1'b1;
    wait_clk(20);
    exp_q = '{10'h016, 10'h017, 10'h018, 10'h019, 10'h01A, 10'h01B, 10'h01C, 10'h01D};
    check_events("ovf_drain", ebase, exp_q);
    check("ovf_empty", 32'(fifo_level), 0);
    check("ovf_sticky", 32'(overflow), 1);
    clr_ovf = 1'b1;
    wait_clk(1);
    clr_ovf = 1'b0;
    wait_clk(1);
    check("ovf_clr", 32'(overflow), 0);

    // Timeout: start + 3 data bits, then line idles
    eb = err_cnt;
    send_bits(8'h1C, 1'b0, 1'b1, 4);
    wait_clk(49900);
    check("to_early", 32'(err_cnt - eb), 0);
    wait_clk(200);
    check("to_err", 32'(err_cnt - eb), 1);
    ebase = ev_q.size();
    send(8'h1C);
    wait_clk(30);
    exp_q = '{10'h01C};
    check_events("to_next", ebase, exp_q);
    check("to_next_err", 32'(err_cnt - eb), 1);

    // Reset mid-frame discards the partial frame
    send_bits(8'h55, 1'b0, 1'b1, 5);
    do_reset();
    check("midrst_level", 32'(fifo_level), 0);
    eb = err_cnt; ebase = ev_q.size();
    send(8'h2A);
    wait_clk(30);
    exp_q = '{10'h02A};
    check_events("midrst_next", ebase, exp_q);
    check("midrst_err", 32'(err_cnt - eb), 0);

    // Typematic sequence 1C 1C 1C F0 1C 1C
    do_reset();
    ebase = ev_q.size();
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); send(8'h1C);
    wait_clk(30);
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_q = '{10'h01C, 10'h11C, 10'h01C};
    check_events("typm", ebase, exp_q);
    check("typm_kcnt", 32'(key_count), 2);
`else
    exp_q = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
    check_events("typm", ebase, exp_q);
    check("typm_kcnt", 32'(key_count), 4);
`endif
    check("typm_ovf", 32'(overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
